// File: rtl/readout_serializer_pkg.sv
// Shared types and constants for the readout serializer: FSM state encoding,
// default widths and the byte-lane count of a sample word.
package readout_serializer_pkg;

   localparam int DEF_SDW   = 32;
   localparam int DEF_CW    = 16;
   localparam int NUM_LANES = DEF_SDW / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Width of a lane index; a single-lane word still needs one bit.
   function automatic int lane_idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/readout_serializer_if.sv
// Bundle of the serializer's control, memory-read and UART-byte signals.
// Names carry the serializer's own direction (_i into it, _o out of it).
//
// Handshakes: a word moves when rd_ready_o && rd_valid_i at a rising clk edge;
// a byte moves when tx_valid_o && tx_ready_i at a rising clk edge. tx_valid_o,
// once high, stays high with tx_data_o stable until that byte moves.
interface readout_serializer_if
   import readout_serializer_pkg::*;
#(
   parameter int SDW = DEF_SDW,
   parameter int CW  = DEF_CW
);
   logic             start_i;
   logic [CW-1:0]    word_count_i;
   logic             busy_o;
   logic             done_o;
   logic             rd_ready_o;
   logic             rd_valid_i;
   logic [SDW/8-1:0] rd_keep_i;
   logic [SDW-1:0]   rd_data_i;
   logic             tx_valid_o;
   logic [7:0]       tx_data_o;
   logic             tx_ready_i;
   state_t           dbg_state_o;

   modport master (
      output start_i, word_count_i, rd_valid_i, rd_keep_i, rd_data_i, tx_ready_i,
      input  busy_o, done_o, rd_ready_o, tx_valid_o, tx_data_o, dbg_state_o
   );

   modport slave (
      input  start_i, word_count_i, rd_valid_i, rd_keep_i, rd_data_i, tx_ready_i,
      output busy_o, done_o, rd_ready_o, tx_valid_o, tx_data_o, dbg_state_o
   );
endinterface

// File: rtl/readout_serializer_byte_pick.sv
// Priority pick of the next pending byte lane: its index and a one-hot clear.
// READOUT_BIG_ENDIAN_EN selects highest-lane-first; otherwise lowest-lane-first.
module readout_byte_pick
   import readout_serializer_pkg::*;
#(
   parameter int NB = NUM_LANES,
   parameter int IW = lane_idx_w(NB)
) (
   input  logic [NB-1:0] mask_i,
   output logic [IW-1:0] idx_o,
   output logic [NB-1:0] clr_o,
   output logic          any_o
);

   // The last hit in the scan wins, so the scan runs away from the priority end.
   always_comb begin
      idx_o = '0;
      clr_o = '0;
`ifdef READOUT_BIG_ENDIAN_EN
      for (int i = 0; i < NB; i++) begin
         if (mask_i[i]) begin
            idx_o = IW'(i);
            clr_o = NB'(1) << i;
         end
      end
`else
      for (int i = NB - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = IW'(i);
            clr_o = NB'(1) << i;
         end
      end
`endif
   end

   assign any_o = |mask_i;

endmodule

// File: rtl/readout_serializer.sv
// Reads word_count memory words and streams their enabled bytes to a UART.
// Byte order within a word follows READOUT_BIG_ENDIAN_EN (see readout_byte_pick).
module readout_serializer
   import readout_serializer_pkg::*;
#(
   parameter int SDW = DEF_SDW,
   parameter int CW  = DEF_CW
) (
   input  logic             clk,
   input  logic             rst,
   readout_serializer_if.slave bus
);

   localparam int NB = SDW / 8;
   localparam int IW = lane_idx_w(NB);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NB-1:0]   mask_q, mask_d;
   logic [SDW-1:0]  data_q, data_d;

   logic [IW-1:0]   pick_idx;
   logic [NB-1:0]   pick_clr;
   logic            pick_any;
   logic [NB-1:0]   mask_left;
   logic [7:0]      pick_byte;

   readout_byte_pick #(.NB(NB), .IW(IW)) u_pick (
      .mask_i (mask_q),
      .idx_o  (pick_idx),
      .clr_o  (pick_clr),
      .any_o  (pick_any)
   );

   assign mask_left = mask_q & ~pick_clr;

   always_comb begin
      pick_byte = '0;
      for (int i = 0; i < NB; i++) begin
         if (pick_idx == IW'(i)) pick_byte = data_q[i*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.word_count_i != '0) begin
                  cnt_d   = bus.word_count_i;
                  state_d = FETCH;
               end else begin
                  state_d = FIN;
               end
            end
         end
         FETCH: begin
            if (bus.rd_valid_i) begin
               data_d  = bus.rd_data_i;
               mask_d  = bus.rd_keep_i;
               cnt_d   = cnt_q - CW'(1);
               state_d = SEND;
            end
         end
         SEND: begin
            // An all-zero keep word falls straight through on its first SEND cycle.
            if (!pick_any) begin
               state_d = (cnt_q != '0) ? FETCH : FIN;
            end else if (bus.tx_ready_i) begin
               mask_d = mask_left;
               if (mask_left == '0) state_d = (cnt_q != '0) ? FETCH : FIN;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o      = (state_q != IDLE);
      bus.done_o      = (state_q == FIN);
      bus.rd_ready_o  = (state_q == FETCH);
      bus.tx_valid_o  = (state_q == SEND) && pick_any;
      bus.tx_data_o   = ((state_q == SEND) && pick_any) ? pick_byte : 8'h00;
      bus.dbg_state_o = state_q;
   end

endmodule

// File: doc/readout_serializer.md
READOUT_SERIALIZER -- requirements
Module: readout_serializer

Interface
REQ-001 Parameter SDW, default 32: sample word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter CW, default 16: width of the word counter.
REQ-003 clk input 1: clock; all state SHALL be updated on its rising edge.
REQ-004 rst input 1: reset, asynchronous, active-high.
REQ-005 start input 1: one-cycle pulse that begins a readout of word_count words.
REQ-006 word_count input CW: number of memory words to read; sampled only on an accepted start.
REQ-007 busy output 1: high from the accepted start until done.
REQ-008 done output 1: one-cycle pulse when the readout completes.
REQ-009 rd_ready output 1: request and accept one memory word.
REQ-010 rd_valid input 1: the memory word is valid.
REQ-011 rd_keep input SDW/8: byte-enable of the word; bit i enables byte i.
REQ-012 rd_data input SDW: memory word.
REQ-013 tx_valid output 1: a byte is presented to the UART transmitter.
REQ-014 tx_data output 8: byte presented to the UART transmitter.
REQ-015 tx_ready input 1: the transmitter accepts the byte.

Function
REQ-016 The state machine SHALL have the states IDLE, FETCH, SEND and FIN.
REQ-017 IDLE: start with word_count>0 SHALL load the counter and go to FETCH.
- start with word_count=0 SHALL go to FIN, with no read.
- start while busy=1 SHALL be ignored.
REQ-018 FETCH: rd_ready=1. On rd_valid=1 the block SHALL latch data and keep, decrement the counter, and go to SEND.
REQ-019 SEND: tx_valid=1, and tx_data SHALL be the lowest-index pending enabled byte.
- On tx_ready=1 that byte SHALL be cleared from the pending mask.
- When the mask empties, the next state SHALL be FETCH if the counter is nonzero, otherwise FIN.
REQ-020 A word latched with keep=0 SHALL emit no bytes; the next state SHALL follow the empty-mask rule of REQ-019 on the following cycle.
REQ-021 Latency: a word accepted in cycle N SHALL present its first byte in cycle N+1.
- After the last byte handshake, rd_ready SHALL reassert in the next cycle.
REQ-022 tx_data and tx_valid SHALL be held stable while tx_valid=1 and tx_ready=0.
- tx_valid SHALL never drop without a handshake.
REQ-023 rd_ready SHALL be 0 in every state except FETCH.
- rd_valid SHALL be ignored while rd_ready=0.
REQ-024 FIN: done=1 for exactly one cycle, then the next state SHALL be IDLE; busy SHALL be 0 in IDLE.
REQ-025 The counter SHALL never wrap: a word_count of 2^CW-1 SHALL read exactly 2^CW-1 words.
REQ-026 A start pulse in the same cycle as done SHALL be ignored.

Reset
REQ-027 During rst the state SHALL be IDLE, and the counter, pending mask and data register SHALL be 0.
REQ-028 During rst the outputs SHALL be busy=0, done=0, rd_ready=0, tx_valid=0 and tx_data=0.
REQ-029 rst asserted mid-readout SHALL abort immediately with no done pulse; operation SHALL resume only on a new start after rst deasserts.

Configuration
REQ-030 Macro READOUT_BIG_ENDIAN_EN: when defined, SEND SHALL emit the highest-index pending enabled byte first.
- When the macro is undefined, lowest-index-first order SHALL apply.
- Every other behaviour SHALL be identical in both builds.

Structure
REQ-031 The shared package SHALL hold the state enum type and the SDW/8 byte-lane count constant.
REQ-032 One sub-module, readout_byte_pick, SHALL implement the combinational priority pick of the next pending byte (index and one-hot clear mask), selected by the endianness build option.

Verification
REQ-033 start, word_count=2, words 0x44332211 and 0x88776655 with keep=4'hF, tx_ready=1 -> tx_data 11,22,33,44,55,66,77,88 on consecutive handshakes, then a single done pulse.
REQ-034 keep=4'b0101 on data 0xDDCCBBAA -> exactly AA then CC; with READOUT_BIG_ENDIAN_EN -> CC then AA.
REQ-035 tx_ready held 0 for 5 cycles during SEND -> tx_data unchanged and tx_valid=1 throughout; rd_ready=0.
REQ-036 word_count=0 -> done one cycle after start, rd_ready never 1; a second start while busy -> no effect.
REQ-037 keep=0 on word 1 of 3 -> no bytes from that word, counter advances, done after word 3.
REQ-038 rst asserted during SEND of word 2 -> all outputs 0 in the same cycle, no done; a new start then reads from word 1.
